token_decoder: RTL and testbench

Inverse of the tokenizing encoder: reads a zero-terminated stream of token IDs from a token RAM. For each ID it locates the matching zero-terminated entry in the vocab RAM and copies that entry's characters into an output RAM. The result is the reconstructed, zero-terminated word. It sits beside the encoder and drives the same single-port synchronous SRAMs (1-cycle read latency) through explicit address/data ports.

---
 rtl/decoder_pkg.sv | 23 ++
 rtl/token_decoder.sv | 165 ++++++++++++++++
 tb/tb_token_decoder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared types and constants for the token decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package decoder_pkg;

    typedef enum logic [3:0] {
        IDLE,
        TOK_REQ,
        TOK_CHK,
        SCAN_REQ,
        SCAN_CHK,
        COPY_REQ,
        COPY_CHK,
        COPY_WR,
        TERM,
        ERR,
        DONE
    } decoder_state;

    // Value that ends a token stream, a vocab entry and the output word.
    localparam int TERMINATOR = 0;

endpackage

// File: rtl/token_decoder.sv
// Token decoder: expands a zero-terminated token-ID stream into characters via a vocab RAM.
// Latency: 2 cycles per token fetch, 2 per scanned vocab byte, 3 per copied char, 3 for the stream end.
// Backpressure: none; SRAMs answer in exactly one cycle, the FSM never stalls.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cs                     start pulse, sampled in IDLE and DONE only
//   tok_addr / tok_dout    token RAM read port (1-cycle latency)
//   voc_addr / voc_dout    vocab RAM read port (1-cycle latency)
//   out_addr/out_din/out_we output RAM write port
//   busy, done, err        status; err qualifies done (1 = aborted)
module token_decoder
    import decoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int VOCAB_END  = 2**ADDR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    output logic [ADDR_WIDTH-1:0] tok_addr,
    input  logic [DATA_WIDTH-1:0] tok_dout,
    output logic [ADDR_WIDTH-1:0] voc_addr,
    input  logic [DATA_WIDTH-1:0] voc_dout,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  out_we,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(VOCAB_END);
    localparam logic [DATA_WIDTH-1:0] TERM_CHAR = DATA_WIDTH'(TERMINATOR);
    localparam logic [DATA_WIDTH-1:0] ONE       = DATA_WIDTH'(1);

    decoder_state          state, state_nxt;
    logic [DATA_WIDTH-1:0] skip, skip_nxt;   // entry separators still to pass while scanning
    logic [ADDR_WIDTH-1:0] tok_addr_nxt, voc_addr_nxt, out_addr_nxt;
    logic [DATA_WIDTH-1:0] out_din_nxt;
    logic                  out_we_nxt, busy_nxt, done_nxt, err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            skip     <= '0;
            tok_addr <= '0;
            voc_addr <= '0;
            out_addr <= '0;
            out_din  <= '0;
            out_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            skip     <= skip_nxt;
            tok_addr <= tok_addr_nxt;
            voc_addr <= voc_addr_nxt;
            out_addr <= out_addr_nxt;
            out_din  <= out_din_nxt;
            out_we   <= out_we_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
        end
    end

    // Every output is a register, so write strobes and status flags are
    // computed here for the state being entered, not the current one.
    always_comb begin
        state_nxt    = state;
        skip_nxt     = skip;
        tok_addr_nxt = tok_addr;
        voc_addr_nxt = voc_addr;
        out_addr_nxt = out_addr;
        out_din_nxt  = out_din;
        out_we_nxt   = 1'b0;
        busy_nxt     = busy;
        done_nxt     = done;
        err_nxt      = err;

        case (state)
            IDLE, DONE: begin
                if (cs) begin
                    state_nxt    = TOK_REQ;
                    tok_addr_nxt = '0;
                    out_addr_nxt = '0;
                    err_nxt      = 1'b0;
                    done_nxt     = 1'b0;
                    busy_nxt     = 1'b1;
                end
            end
            TOK_REQ: state_nxt = TOK_CHK;
            TOK_CHK: begin
                if (tok_dout == TERM_CHAR) begin
                    state_nxt   = TERM;
                    out_we_nxt  = 1'b1;
                    out_din_nxt = TERM_CHAR;
                end else begin
                    voc_addr_nxt = '0;
                    skip_nxt     = tok_dout - ONE;
                    state_nxt    = (tok_dout == ONE) ? COPY_REQ : SCAN_REQ;
                end
            end
            SCAN_REQ: state_nxt = SCAN_CHK;
            SCAN_CHK: begin
                // The wanted entry must start inside the RAM, so the last
                // byte can never be a useful separator.
                if (voc_addr == LAST_ADDR) begin
                    state_nxt = ERR;
                end else begin
                    voc_addr_nxt = voc_addr + 1'b1;
                    state_nxt    = SCAN_REQ;
                    if (voc_dout == TERM_CHAR) begin
                        skip_nxt = skip - ONE;
                        if (skip == ONE)
                            state_nxt = COPY_REQ;
                    end
                end
            end
            COPY_REQ: state_nxt = COPY_CHK;
            COPY_CHK: begin
                if (voc_dout == TERM_CHAR) begin
                    if (tok_addr == LAST_ADDR) begin
                        state_nxt = ERR;
                    end else begin
                        tok_addr_nxt = tok_addr + 1'b1;
                        state_nxt    = TOK_REQ;
                    end
                end else if (out_addr == LAST_ADDR || voc_addr == LAST_ADDR) begin
                    // No room for the word terminator, or the entry runs off the RAM.
                    state_nxt = ERR;
                end else begin
                    state_nxt   = COPY_WR;
                    out_we_nxt  = 1'b1;
                    out_din_nxt = voc_dout;
                end
            end
            COPY_WR: begin
                out_addr_nxt = out_addr + 1'b1;
                voc_addr_nxt = voc_addr + 1'b1;
                state_nxt    = COPY_REQ;
            end
            TERM: begin
                state_nxt = DONE;
                done_nxt  = 1'b1;
                err_nxt   = 1'b0;
                busy_nxt  = 1'b0;
            end
            ERR: begin
                state_nxt = DONE;
                done_nxt  = 1'b1;
                err_nxt   = 1'b1;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_token_decoder.sv
module tb_token_decoder;
    import decoder_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk, rst, cs;
    logic [AW-1:0] tok_addr, voc_addr, out_addr;
    logic [DW-1:0] tok_dout, voc_dout, out_din;
    logic          out_we, busy, done, err;

    token_decoder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .VOCAB_END(2**AW-1)) dut (
        .clk(clk), .rst(rst), .cs(cs),
        .tok_addr(tok_addr), .tok_dout(tok_dout),
        .voc_addr(voc_addr), .voc_dout(voc_dout),
        .out_addr(out_addr), .out_din(out_din), .out_we(out_we),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAMs, one-cycle read latency
    logic [DW-1:0] tok_mem [16];
    logic [DW-1:0] voc_mem [16];
    logic [DW-1:0] out_mem [16];

    always @(posedge clk) begin
        tok_dout <= tok_mem[tok_addr];
        voc_dout <= voc_mem[voc_addr];
        if (out_we) out_mem[out_addr] <= out_din;
    end

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Write log and protocol watch, sampled mid-cycle
    int       wa[$];
    int       wd[$];
    int       viol = 0;
    int       voc_chg = 0;
    logic     prev_we = 1'b0;
    logic [AW-1:0] prev_voc = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_we) begin
                wa.push_back(int'(out_addr));
                wd.push_back(int'(out_din));
                if (prev_we) viol++;
            end
            if (done && busy) viol++;
            if (voc_addr != prev_voc) voc_chg++;
        end
        prev_we  = out_we;
        prev_voc = voc_addr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: walks the streams by the decoding rules directly.
    int ea[$];
    int ed[$];
    int exp_err;
    int exp_lat;   // clock edges from the start edge until done is seen high

    task automatic model();
        int  t, o, a, id, zeros, start;
        bit  stop, found;
        ea.delete(); ed.delete();
        exp_err = 0; exp_lat = 0; t = 0; o = 0; stop = 0;
        while (!stop) begin
            id = int'(tok_mem[t]);
            exp_lat += 2;
            if (id == 0) begin
                ea.push_back(o); ed.push_back(0);
                exp_lat += 1;
                stop = 1;
            end else begin
                start = 0; found = (id == 1); zeros = 0;
                for (int p = 0; p <= 14 && !found; p++) begin
                    exp_lat += 2;
                    if (voc_mem[p] == 0) begin
                        zeros++;
                        if (zeros == id - 1) begin found = 1; start = p + 1; end
                    end
                end
                if (!found) begin
                    exp_err = 1; stop = 1;
                end else begin
                    a = start;
                    while (1) begin
                        exp_lat += 2;
                        if (voc_mem[a] == 0) begin
                            if (t == 15) begin exp_err = 1; stop = 1; end
                            else t++;
                            break;
                        end
                        if (o == 15 || a == 15) begin exp_err = 1; stop = 1; break; end
                        ea.push_back(o); ed.push_back(int'(voc_mem[a]));
                        exp_lat += 1;
                        o++; a++;
                    end
                end
            end
        end
    endtask

    task automatic clear_mems(input logic [DW-1:0] voc_fill);
        for (int i = 0; i < 16; i++) begin
            tok_mem[i] = '0;
            voc_mem[i] = voc_fill;
            out_mem[i] = 8'hEE;
        end
    endtask

    task automatic start_pulse();
        @(negedge clk); cs = 1'b1;
        @(posedge clk); #1 cs = 1'b0;
    endtask

    task automatic run_case(input string name, input bit chk_lat);
        int cyc;
        int n;
        model();
        wa.delete(); wd.delete(); voc_chg = 0;
        start_pulse();
        chk({name, ".busy_start"}, 32'(busy), 32'd1);
        chk({name, ".done_clr"}, 32'(done), 32'd0);
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, ".done"}, 32'(done), 32'd1);
        chk({name, ".err"}, 32'(err), 32'(exp_err));
        chk({name, ".busy_end"}, 32'(busy), 32'd0);
        if (chk_lat && exp_err == 0) chk({name, ".latency"}, 32'(cyc), 32'(exp_lat));
        chk({name, ".nwrites"}, 32'(wa.size()), 32'(ea.size()));
        n = (wa.size() < ea.size()) ? wa.size() : ea.size();
        for (int i = 0; i < n; i++) begin
            chk({name, ".waddr"}, 32'(wa[i]), 32'(ea[i]));
            chk({name, ".wdata"}, 32'(wd[i]), 32'(ed[i]));
        end
    endtask

    initial begin
        int n;
        int cyc;
        rst = 1'b1; cs = 1'b0;
        clear_mems(8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.state", 32'(dut.state), 32'(IDLE));
        chk("rst.tok_addr", 32'(tok_addr), 32'd0);
        chk("rst.voc_addr", 32'(voc_addr), 32'd0);
        chk("rst.out_addr", 32'(out_addr), 32'd0);
        chk("rst.out_din", 32'(out_din), 32'd0);
        chk("rst.out_we", 32'(out_we), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        rst = 1'b0;

        // "ab\0c\0", tokens [2,1,0] -> c a b 0
        clear_mems(8'h00);
        voc_mem[0] = "a"; voc_mem[1] = "b"; voc_mem[3] = "c";
        tok_mem[0] = 8'd2; tok_mem[1] = 8'd1;
        run_case("basic", 1'b1);
        chk("basic.lat_const", 32'(exp_lat), 32'd26);
        chk("basic.out0", 32'(out_mem[0]), 32'h63);
        chk("basic.out1", 32'(out_mem[1]), 32'h61);
        chk("basic.out2", 32'(out_mem[2]), 32'h62);
        chk("basic.out3", 32'(out_mem[3]), 32'h00);
        repeat (3) @(negedge clk);
        chk("basic.done_hold", 32'(done), 32'd1);
        chk("basic.we_idle", 32'(out_we), 32'd0);

        // Empty stream: single terminator write, no vocab traffic
        clear_mems(8'h00);
        voc_mem[0] = "q";
        run_case("empty", 1'b1);
        chk("empty.lat", 32'(exp_lat), 32'd3);
        chk("empty.voc_idle", 32'(voc_chg), 32'd0);

        // "a\0\0b\0", tokens [2,3,0] -> "b\0"
        clear_mems(8'h00);
        voc_mem[0] = "a"; voc_mem[3] = "b";
        tok_mem[0] = 8'd2; tok_mem[1] = 8'd3;
        run_case("empty_entry", 1'b1);
        chk("empty_entry.out0", 32'(out_mem[0]), 32'h62);
        chk("empty_entry.out1", 32'(out_mem[1]), 32'h00);

        // Two entries, token 5: scan runs off the vocab
        clear_mems(8'h7A);
        voc_mem[0] = "a"; voc_mem[1] = 8'h00; voc_mem[2] = "b"; voc_mem[3] = 8'h00;
        tok_mem[0] = 8'd5;
        run_case("scan_end", 1'b1);
        chk("scan_end.err_const", 32'(err), 32'd1);
        chk("scan_end.no_write", 32'(wa.size()), 32'd0);

        // Sixteen copies of a one-char entry: output space runs out
        clear_mems(8'h00);
        voc_mem[0] = "x";
        for (int i = 0; i < 16; i++) tok_mem[i] = 8'd1;
        run_case("out_full", 1'b1);
        chk("out_full.err_const", 32'(err), 32'd1);
        chk("out_full.nwr_const", 32'(wa.size()), 32'd15);

        // Reset during the second character write, then a clean rerun
        clear_mems(8'h00);
        voc_mem[0] = "a"; voc_mem[1] = "b"; voc_mem[3] = "c";
        tok_mem[0] = 8'd2; tok_mem[1] = 8'd1;
        start_pulse();
        n = 0; cyc = 0;
        while (n < 2 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (out_we) n++;
        end
        chk("rstmid.reached", 32'(n), 32'd2);
        chk("rstmid.in_wr", 32'(dut.state), 32'(COPY_WR));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid.state", 32'(dut.state), 32'(IDLE));
        chk("rstmid.outs", {tok_addr, voc_addr, out_addr, out_din, out_we, busy, done, err}, 32'd0);
        @(negedge clk); rst = 1'b0;
        run_case("rerun", 1'b1);

        // Randomised streams against the model
        for (int r = 0; r < 25; r++) begin
            int ntok;
            clear_mems(8'h00);
            for (int i = 0; i < 16; i++) begin
                voc_mem[i] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                tok_mem[i] = 8'($urandom_range(1, 255));
            end
            ntok = $urandom_range(0, 5);
            for (int j = 0; j < ntok; j++) tok_mem[j] = 8'($urandom_range(1, 4));
            tok_mem[ntok] = 8'h00;
            run_case("rand", 1'b1);
        end

        chk("protocol_violations", 32'(viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
